ex_mem_stage: RTL

Pipeline stage directly downstream of the execute-stage ALU/multiplier. Each cycle it selects the ALU, multiplier or link (PC+4) result, registers it with the instruction's writeback and memory-control fields, and produces byte-lane-aligned store data and write strobes for data memory. It drives an EX→ID forwarding port and applies a valid/ready handshake, so memory stalls and branch flushes propagate correctly.

---
 rtl/ex_mem_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with result select, store lane alignment and EX->ID forwarding; define MUL_2CYCLE_EN for a 2-cycle multiply
module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] mul_out,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      sel,
    input  logic [REGW-1:0] rd,
    input  logic            rd_wen,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ex_result,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_wen,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_web,
    output logic            misalign,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);
    logic            free, accept, mis;
    logic [1:0]      a, f;
    logic [3:0]      web;
    logic [XLEN-1:0] res, wdata, mul_res;

    assign free   = !out_valid | out_ready;
    assign accept = in_valid & in_ready & !flush;
    assign a      = alu_out[1:0];
    assign f      = funct3[1:0];

`ifdef MUL_2CYCLE_EN
    typedef enum logic {IDLE, WAIT} state_t;
    state_t          state, state_n;
    logic [XLEN-1:0] mul_q;
    logic            start;

    assign mul_res = (state == WAIT) ? mul_q : mul_out;

    // Multiply FSM: IDLE captures a new multiply and stalls upstream; WAIT retires it on load or flush
    always_comb begin
        state_n  = state;
        start    = 1'b0;
        in_ready = flush | free;
        if (state == IDLE) begin
            if (in_valid & (sel == 2'b01) & !flush) begin
                start    = 1'b1;
                in_ready = 1'b0;
                state_n  = WAIT;
            end
        end else if (flush | (in_valid & free)) begin
            state_n = IDLE;
        end
    end

    // FSM state and captured multiplier result
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mul_q <= '0;
        end else begin
            state <= state_n;
            if (start) mul_q <= mul_out;
        end
    end
`else
    assign mul_res  = mul_out;
    assign in_ready = flush | free;
`endif

    // Result select, store lane replication/strobes and misalignment detection
    always_comb begin
        res   = (sel == 2'b01) ? mul_res : (sel == 2'b10) ? pc_plus4 : alu_out;
        mis   = (mem_read | mem_write) &
                ((f == 2'b11) | ((f == 2'b01) & a[0]) | ((f == 2'b10) & (a != 2'b00)));
        web   = (!mem_write | mis) ? 4'b0000 :
                (f == 2'b00) ? (4'b0001 << a) :
                (f == 2'b01) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = (f == 2'b00) ? {(XLEN/8){store_data[7:0]}} :
                (f == 2'b01) ? {(XLEN/16){store_data[15:0]}} : store_data;
    end

    // Output register: loads the accepted payload or a bubble whenever free, otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            ex_result    <= '0;
            ex_rd        <= '0;
            ex_wen       <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_funct3    <= '0;
            mem_wdata    <= '0;
            mem_web      <= '0;
            misalign     <= 1'b0;
        end else if (free) begin
            out_valid    <= accept;
            ex_result    <= res;
            ex_rd        <= rd;
            ex_wen       <= accept & rd_wen & (rd != '0);
            ex_mem_read  <= accept & mem_read;
            ex_mem_write <= accept & mem_write;
            ex_funct3    <= funct3;
            mem_wdata    <= wdata;
            mem_web      <= accept ? web : 4'b0000;
            misalign     <= accept & mis;
        end
    end

    assign fwd_valid = out_valid & ex_wen & !ex_mem_read;
    assign fwd_rd    = ex_rd;
    assign fwd_data  = ex_result;
endmodule
